arb_rr_pkt: RTL

- Packet-aware round-robin arbiter and multiplexer: shares one valid/ready output stream among WIDTH requester streams.
- Once a requester is granted, it holds the output until its last beat completes; only then does the grant rotate.
- Sits upstream of shared resources such as a common bus port, FIFO write side or DMA channel.
- Replaces per-cycle grant with grant locked per packet.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_rr_pick.sv | 40 ++++
 rtl/arb_rr_pkt.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin arbiter.
// Supports up to OH_MAX requesters.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam int QUOTA_W = 4;
    localparam int OH_MAX  = 32;
    localparam int IDX_MAX = 5;

    function automatic logic [IDX_MAX-1:0] onehot2bin(input logic [OH_MAX-1:0] oh);
        logic [IDX_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (oh[i]) idx = idx | IDX_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational lowest-index pick: masked candidates first, else any valid.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vld,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] win_oh,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    logic [WIDTH-1:0]  cand;
    logic [WIDTH-1:0]  pre_c;
    logic [WIDTH-1:0]  pre_v;
    logic [WIDTH-1:0]  win_c;
    logic [WIDTH-1:0]  win_v;
    logic [OH_MAX-1:0] oh_ext;

    always_comb begin
        cand  = vld & mask;
        pre_c = '0;
        pre_v = '0;
        // pre_x[i] is set when any lower index is asserted
        for (int i = 1; i < WIDTH; i++) begin
            pre_c[i] = pre_c[i-1] | cand[i-1];
            pre_v[i] = pre_v[i-1] | vld[i-1];
        end
        win_c   = cand & ~pre_c;
        win_v   = vld & ~pre_v;
        win_oh  = (|cand) ? win_c : win_v;
        any     = |vld;
        oh_ext  = '0;
        oh_ext[WIDTH-1:0] = win_oh;
        win_idx = IW'(onehot2bin(oh_ext));
    end

endmodule

// File: rtl/arb_rr_pkt.sv
// Packet-locked round-robin arbiter/mux; grant rotates only after an owner's last beat.
// Optional per-requester packet quota enabled with ARB_RR_PKT_QUOTA_EN.
module arb_rr_pkt
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DW    = 32,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ARB_RR_PKT_QUOTA_EN
    input  logic [WIDTH*QUOTA_W-1:0] quota,
`endif
    input  logic [WIDTH-1:0]      req_vld,
    input  logic [WIDTH-1:0]      req_last,
    input  logic [WIDTH*DW-1:0]   req_data,
    output logic [WIDTH-1:0]      req_rdy,
    output logic                  out_vld,
    output logic                  out_last,
    output logic [DW-1:0]         out_data,
    input  logic                  out_rdy,
    output logic [WIDTH-1:0]      grant_oh,
    output logic [IW-1:0]         grant_idx,
    output logic                  busy
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] grant_oh_q, grant_oh_d;
    logic [IW-1:0]    grant_idx_q, grant_idx_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] pick_mask;
    logic [WIDTH-1:0] above_g;
    logic [WIDTH-1:0] from_g;
    logic [WIDTH-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic             last_hs;
    logic             advance;

    arb_rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_pick (
        .vld     (req_vld),
        .mask    (pick_mask),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Datapath: the owner's stream is routed straight through while BUSY
    always_comb begin
        out_vld  = 1'b0;
        out_last = 1'b0;
        out_data = '0;
        req_rdy  = '0;
        if (state_q == ARB_BUSY) begin
            out_vld  = req_vld[grant_idx_q];
            out_last = req_last[grant_idx_q];
            out_data = req_data[grant_idx_q*DW +: DW];
            req_rdy  = grant_oh_q & {WIDTH{out_rdy}};
        end
    end

    assign last_hs = (state_q == ARB_BUSY) & out_vld & out_rdy & out_last;

    always_comb begin
        above_g = '0;
        from_g  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            above_g[i] = (grant_idx_q <  IW'(i));
            from_g[i]  = (grant_idx_q <= IW'(i));
        end
    end

`ifdef ARB_RR_PKT_QUOTA_EN
    logic [QUOTA_W-1:0] cnt_q, cnt_d;
    logic [QUOTA_W-1:0] q_raw;
    logic [QUOTA_W-1:0] q_eff;

    always_comb begin
        q_raw   = quota[grant_idx_q*QUOTA_W +: QUOTA_W];
        q_eff   = (q_raw == '0) ? QUOTA_W'(1) : q_raw;
        advance = (({1'b0, cnt_q} + 5'd1) >= {1'b0, q_eff}) | ~req_vld[grant_idx_q];
    end

    // Counts consecutive packets of the current owner; any owner change restarts it
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else if (last_hs) begin
            if (advance || !win_any || (win_idx != grant_idx_q))
                cnt_d = '0;
            else
                cnt_d = cnt_q + QUOTA_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign advance = 1'b1;
`endif

    // A held owner keeps itself as lowest candidate; otherwise priority moves past it
    always_comb begin
        pick_mask = mask_q;
        if (state_q == ARB_BUSY) pick_mask = advance ? above_g : from_g;
    end

    always_comb begin
        state_d     = state_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        mask_d      = mask_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d     = ARB_BUSY;
                    grant_oh_d  = win_oh;
                    grant_idx_d = win_idx;
                end
            end
            ARB_BUSY: begin
                if (last_hs) begin
                    mask_d = pick_mask;
                    if (win_any) begin
                        grant_oh_d  = win_oh;
                        grant_idx_d = win_idx;
                    end else begin
                        state_d     = ARB_IDLE;
                        grant_oh_d  = '0;
                        grant_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                grant_oh_d  = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            mask_q      <= '1;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            mask_q      <= mask_d;
        end
    end

    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == ARB_BUSY);

endmodule
